clz_sequencer: RTL and testbench
================================

Name: clz_sequencer

Overview:
- Multi-cycle leading-zero/leading-one count unit for the CLZ and CLO instructions in the pipelined MIPS CPU.
- Scans the operand STEP_BITS bits per cycle from the MSB down and exits as soon as it finds the first set bit.
- Sits in the EX stage beside the ALU and holds the pipeline with a stall output while it works.
- Replaces the single-cycle combinational count path so that path no longer limits the clock period.

Parameters:
- DATA_WIDTH, 32, operand and result width; must be a multiple of STEP_BITS.
- STEP_BITS, 4, bits examined per SCAN cycle; must be a power of two, 1 to 8.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a count; sampled only in IDLE or DONE.
- op_clo  input  1  1 = count leading ones (CLO), 0 = count leading zeros (CLZ); sampled with start.
- data_in  input  DATA_WIDTH  operand; sampled with start.
- flush  input  1  pipeline flush; aborts any operation in progress.
- busy  output  1  high in SCAN.
- done  output  1  one-cycle pulse; result is valid in this cycle.
- result  output  DATA_WIDTH  count, 0 to DATA_WIDTH; zero-extended.
- stall  output  1  combinational; pipeline hold request to the hazard unit.

Behaviour:
- Reset, asynchronous on rst_n low:
  - state = IDLE.
  - busy = 0, done = 0, result = 0.
  - Internal shift register = 0, count register = 0.
- States: IDLE, SCAN, DONE. Encodings are defined in define.v.
- IDLE:
  - start = 1 → latch shreg = op_clo ? ~data_in : data_in, set cnt = 0, go to SCAN.
  - start = 0 → stay in IDLE.
- SCAN, once per cycle:
  - Inspect top = shreg[DATA_WIDTH-1 -: STEP_BITS].
  - top == 0 and cnt + STEP_BITS < DATA_WIDTH → cnt += STEP_BITS, shreg <<= STEP_BITS, stay in SCAN.
  - top == 0 and cnt + STEP_BITS == DATA_WIDTH → result = DATA_WIDTH, go to DONE.
  - top != 0 → result = cnt + lz(top), where lz is the sub-module's leading-zero count of top (0 to STEP_BITS-1); go to DONE.
- DONE:
  - done = 1 for exactly this cycle.
  - start = 1 → accept a new operand exactly as in IDLE and go to SCAN (back-to-back operation).
  - start = 0 → go to IDLE.
- result holds its value until the next DONE entry. It is not cleared in IDLE.
- Latency:
  - Number of SCAN cycles n = min(floor(lz_total / STEP_BITS) + 1, DATA_WIDTH / STEP_BITS).
  - done is asserted n + 1 cycles after the cycle in which start was sampled high.
  - Default worst case (operand 0): 8 SCAN cycles, done 9 cycles after start.
- stall = (state == IDLE or DONE) && start, OR state == SCAN.
  - stall is low in the cycle done is high unless a new start is accepted in that cycle.
- start while in SCAN is ignored. The hazard unit guarantees it does not occur.
- flush = 1 in any state → next state IDLE, done is not asserted, result is unchanged.
  - flush has priority over start and over SCAN completion in the same cycle.
- Reset asserted mid-SCAN → immediate return to the reset values above; no done pulse is produced.
- Width rule: the count register is clog2(DATA_WIDTH)+1 bits wide, so it can hold DATA_WIDTH exactly; it is zero-extended onto result.
- CLO on 0xFFFFFFFF → inverted operand is 0 → result 32.

Decomposition:
- define.v (shared `include):
  - state encodings CLZ_IDLE, CLZ_SCAN, CLZ_DONE (2 bits).
  - the existing `ENABLED / `DISABLED constants, used for start, flush and op_clo comparisons.
- Sub-module lz_step_enc, parameterized by STEP_BITS:
  - combinational priority encoder returning the leading-zero count of a nonzero STEP_BITS-bit slice.
  - instantiated once inside clz_sequencer.

Test Plan:
- CLZ, data_in = 0x80000000 → 1 SCAN cycle; done 2 cycles after start; result = 0; stall high for cycles 0–1, low in the done cycle.
- CLZ, data_in = 0x00010000 → 4 SCAN cycles; done 5 cycles after start; result = 15.
- CLZ, data_in = 0x00000000 → 8 SCAN cycles; done 9 cycles after start; result = 32. CLO, data_in = 0xFFFFFFFF → result = 32.
- CLO, data_in = 0xF0FFFFFF → result = 4. Back-to-back: start held high in the DONE cycle with CLZ 0x00000001 → next done 9 cycles later with result = 31, no idle cycle in between.
- CLZ 0x00000000 started, flush pulsed on the 3rd SCAN cycle → state IDLE next cycle; no done; result keeps its previous value; stall low.
- rst_n driven low asynchronously mid-SCAN (between clock edges) → busy, done and result go to 0 immediately. After rst_n release, start with 0x00F00000 → result = 8.

Source files
------------

// File: rtl/clz_sequencer_pkg.sv
// +----------------------------------------------------------------------+
// | clz_sequencer_pkg: shared state encoding and flag constants          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package clz_sequencer_pkg;

  typedef enum logic [1:0] {
    CLZ_IDLE = 2'd0,
    CLZ_SCAN = 2'd1,
    CLZ_DONE = 2'd2
  } clz_state_e;

  localparam logic ENABLED  = 1'b1;
  localparam logic DISABLED = 1'b0;

endpackage

`default_nettype wire

// File: rtl/clz_sequencer_lz_step_enc.sv
// +----------------------------------------------------------------------+
// | lz_step_enc: leading-zero count of a nonzero STEP_BITS-wide slice    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module lz_step_enc #(
  parameter int STEP_BITS = 4,
  parameter int LZ_W      = (STEP_BITS > 1) ? $clog2(STEP_BITS) : 1
) (
  input  logic [STEP_BITS-1:0] slice_i,
  output logic [LZ_W-1:0]      lz_o
);

  // Scanning upward lets the highest set bit win the last assignment.
  always_comb begin
    lz_o = '0;
    for (int i = 0; i < STEP_BITS; i++) begin
      if (slice_i[i]) begin
        lz_o = LZ_W'(STEP_BITS - 1 - i);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/clz_sequencer.sv
// +----------------------------------------------------------------------+
// | clz_sequencer: multi-cycle CLZ/CLO unit, STEP_BITS bits per cycle    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module clz_sequencer
  import clz_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int STEP_BITS  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  op_clo,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  flush,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  stall
);

  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
  localparam int LZ_W  = (STEP_BITS > 1) ? $clog2(STEP_BITS) : 1;

  clz_state_e              state_q, state_d;
  logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   result_q, result_d;
  logic [STEP_BITS-1:0]    top_w;
  logic [LZ_W-1:0]         lz_w;
  logic [CNT_W-1:0]        cnt_step_w;

  assign top_w      = shreg_q[DATA_WIDTH-1 -: STEP_BITS];
  assign cnt_step_w = cnt_q + CNT_W'(STEP_BITS);

  lz_step_enc #(
    .STEP_BITS (STEP_BITS),
    .LZ_W      (LZ_W)
  ) u_lz_step_enc (
    .slice_i (top_w),
    .lz_o    (lz_w)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= CLZ_IDLE;
      shreg_q  <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    stall    = 1'b0;
    case (state_q)
      CLZ_IDLE, CLZ_DONE: begin
        if (start == ENABLED) begin
          // CLO reduces to CLZ of the inverted operand.
          shreg_d = (op_clo == ENABLED) ? ~data_in : data_in;
          cnt_d   = '0;
          state_d = CLZ_SCAN;
          stall   = 1'b1;
        end else begin
          state_d = CLZ_IDLE;
        end
      end
      CLZ_SCAN: begin
        stall = 1'b1;
        if (top_w == '0) begin
          if (cnt_step_w < CNT_W'(DATA_WIDTH)) begin
            cnt_d   = cnt_step_w;
            shreg_d = shreg_q << STEP_BITS;
          end else begin
            result_d = DATA_WIDTH'(DATA_WIDTH);
            state_d  = CLZ_DONE;
          end
        end else begin
          result_d = DATA_WIDTH'(cnt_q + CNT_W'(lz_w));
          state_d  = CLZ_DONE;
        end
      end
      default: state_d = CLZ_IDLE;
    endcase
    // Flush overrides both a new start and a finishing scan.
    if (flush == ENABLED) begin
      state_d  = CLZ_IDLE;
      shreg_d  = shreg_q;
      cnt_d    = cnt_q;
      result_d = result_q;
    end
  end

  assign busy   = (state_q == CLZ_SCAN);
  assign done   = (state_q == CLZ_DONE);
  assign result = result_q;

endmodule

`default_nettype wire

// File: tb/tb_clz_sequencer.sv
// +----------------------------------------------------------------------+
// | tb_clz_sequencer: directed self-checking bench for clz_sequencer     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_clz_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        op_clo;
  logic [31:0] data_in;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        stall;

  int checks;
  int errors;

  clz_sequencer #(
    .DATA_WIDTH (32),
    .STEP_BITS  (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op_clo  (op_clo),
    .data_in (data_in),
    .flush   (flush),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .stall   (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called just after a negedge; start is sampled at the next posedge.
  task automatic launch(input logic clo, input logic [31:0] d);
    start   = 1'b1;
    op_clo  = clo;
    data_in = d;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Cycles from the start-sampling edge until done is seen; -1 on timeout.
  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done) begin
        cyc = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b result=%h stall=%b, expected 0/0/0/0",
               busy, done, result, stall);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_clz_msb;
    int cyc;
    start = 1'b1; op_clo = 1'b0; data_in = 32'h8000_0000;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL msb_stall_c0: got %b expected 1", stall);
    end
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    checks++;
    if (stall !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL msb_stall_c1: stall=%b busy=%b expected 1/1", stall, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || stall !== 1'b0 || result !== 32'd0) begin
      errors++;
      $display("FAIL msb_done_c2: done=%b stall=%b result=%0d expected 1/0/0",
               done, stall, result);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL msb_done_pulse: done=%b expected 0", done);
    end
    cyc = 0;
  endtask

  task automatic test_clz_mid;
    int cyc;
    launch(1'b0, 32'h0001_0000);
    wait_done(cyc);
    checks++;
    if (cyc != 5 || result !== 32'd15) begin
      errors++;
      $display("FAIL clz_mid: latency=%0d result=%0d expected 5/15", cyc, result);
    end
    @(negedge clk);
  endtask

  task automatic test_full_width;
    int cyc;
    launch(1'b0, 32'h0000_0000);
    wait_done(cyc);
    checks++;
    if (cyc != 9 || result !== 32'd32) begin
      errors++;
      $display("FAIL clz_zero: latency=%0d result=%0d expected 9/32", cyc, result);
    end
    @(negedge clk);
    launch(1'b1, 32'hFFFF_FFFF);
    wait_done(cyc);
    checks++;
    if (cyc != 9 || result !== 32'd32) begin
      errors++;
      $display("FAIL clo_ones: latency=%0d result=%0d expected 9/32", cyc, result);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int cyc;
    launch(1'b1, 32'hF0FF_FFFF);
    wait_done(cyc);
    checks++;
    if (cyc != 3 || result !== 32'd4) begin
      errors++;
      $display("FAIL clo_f0: latency=%0d result=%0d expected 3/4", cyc, result);
    end
    start = 1'b1; op_clo = 1'b0; data_in = 32'h0000_0001;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL b2b_stall: got %b expected 1", stall);
    end
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(cyc);
    checks++;
    if (cyc != 9 || result !== 32'd31) begin
      errors++;
      $display("FAIL b2b_clz_one: latency=%0d result=%0d expected 9/31", cyc, result);
    end
    @(negedge clk);
  endtask

  task automatic test_flush;
    int seen;
    launch(1'b0, 32'h0000_0000);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0 || result !== 32'd31) begin
      errors++;
      $display("FAIL flush: busy=%b done=%b stall=%b result=%0d expected 0/0/0/31",
               busy, done, stall, result);
    end
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL flush_quiet: active cycles=%0d expected 0", seen);
    end
  endtask

  task automatic test_async_reset;
    int cyc;
    launch(1'b0, 32'h0000_0000);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
      errors++;
      $display("FAIL async_reset: busy=%b done=%b result=%0d expected 0/0/0",
               busy, done, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    launch(1'b0, 32'h00F0_0000);
    wait_done(cyc);
    checks++;
    if (cyc != 4 || result !== 32'd8) begin
      errors++;
      $display("FAIL post_reset: latency=%0d result=%0d expected 4/8", cyc, result);
    end
    @(negedge clk);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    start   = 1'b0;
    op_clo  = 1'b0;
    data_in = 32'd0;
    flush   = 1'b0;
    test_reset();
    test_clz_msb();
    test_clz_mid();
    test_full_width();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
